seg_scanner: RTL

SEG_SCANNER -- requirements
Module: seg_scanner

---
 rtl/seg_scanner.sv | 109 ++++++++++
 1 files changed

// File: rtl/seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous value update
// and optional leading-zero suppression.
module seg_scanner #(
    parameter int unsigned TICK_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  point_in,
    input  logic [3:0]  blank_in,
    input  logic        lz_en,
    output logic        ack,
    output logic [3:0]  an,
    output logic [3:0]  data,
    output logic        point,
    output logic        LE
);

    localparam int unsigned CntW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CntW-1:0] TickMax = CntW'(TICK_CYCLES - 1);

    logic [CntW-1:0] tick_q, tick_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     act_val_q, act_val_d;
    logic [3:0]      act_pt_q, act_pt_d;
    logic [3:0]      act_blk_q, act_blk_d;
    logic [15:0]     pend_val_q, pend_val_d;
    logic [3:0]      pend_pt_q, pend_pt_d;
    logic [3:0]      pend_blk_q, pend_blk_d;
    logic            pend_v_q, pend_v_d;
    logic            ack_q, ack_d;

    logic wrap, xfer;
    logic [3:0] zero_from;
    logic [3:0] sup;

    always_comb begin
        wrap       = (tick_q == TickMax);
        xfer       = wrap && (idx_q == 2'd3) && pend_v_q;
        tick_d     = wrap ? '0 : tick_q + CntW'(1);
        idx_d      = wrap ? idx_q + 2'd1 : idx_q;
        act_val_d  = act_val_q;
        act_pt_d   = act_pt_q;
        act_blk_d  = act_blk_q;
        pend_val_d = pend_val_q;
        pend_pt_d  = pend_pt_q;
        pend_blk_d = pend_blk_q;
        pend_v_d   = pend_v_q;
        ack_d      = xfer;
        // Transfer uses the old pending contents; a same-cycle load becomes the new pending.
        if (xfer) begin
            act_val_d = pend_val_q;
            act_pt_d  = pend_pt_q;
            act_blk_d = pend_blk_q;
            pend_v_d  = 1'b0;
        end
        if (load) begin
            pend_val_d = din;
            pend_pt_d  = point_in;
            pend_blk_d = blank_in;
            pend_v_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q     <= '0;
            idx_q      <= 2'd0;
            act_val_q  <= 16'h0000;
            act_pt_q   <= 4'b0000;
            act_blk_q  <= 4'b1111;
            pend_val_q <= 16'h0000;
            pend_pt_q  <= 4'b0000;
            pend_blk_q <= 4'b0000;
            pend_v_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            act_val_q  <= act_val_d;
            act_pt_q   <= act_pt_d;
            act_blk_q  <= act_blk_d;
            pend_val_q <= pend_val_d;
            pend_pt_q  <= pend_pt_d;
            pend_blk_q <= pend_blk_d;
            pend_v_q   <= pend_v_d;
            ack_q      <= ack_d;
        end
    end

    // zero_from[k]: nibbles k..3 of the active value are all zero.
    always_comb begin
        zero_from[3] = (act_val_q[15:12] == 4'h0);
        zero_from[2] = zero_from[3] && (act_val_q[11:8] == 4'h0);
        zero_from[1] = zero_from[2] && (act_val_q[7:4] == 4'h0);
        zero_from[0] = zero_from[1] && (act_val_q[3:0] == 4'h0);
        sup          = {zero_from[3:1], 1'b0} & {4{lz_en}};
    end

    always_comb begin
        ack   = ack_q;
        an    = ~(4'b0001 << idx_q);
        data  = act_val_q[{idx_q, 2'b00} +: 4];
        LE    = ~(act_blk_q[idx_q] | sup[idx_q]);
        point = act_pt_q[idx_q] & LE;
    end

endmodule
